// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter driving one asynchronous SRAM interface.
// Define ARB_ROUND_ROBIN_EN for alternating priority on contention; default is fixed data-port priority.
module mem_arbiter #(
    parameter int RD_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,

    input  logic        mem_req,
    input  logic        mem_we,
    input  logic        mem_byte,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,

    output logic        ram_sel,
    output logic [19:0] ram_addr,
    output logic [3:0]  ram_be_n,
    output logic        ram_ce_n,
    output logic        ram_oe_n,
    output logic        ram_we_n,
    output logic [31:0] ram_wdata,
    output logic        ram_data_oe,
    input  logic [31:0] ram_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    state_t      state, state_nxt;
    logic [2:0]  wait_cnt;
    logic [21:0] addr_q;
    logic [31:0] wdata_q;
    logic        we_q;
    logic        byte_q;
    logic        id_q;        // 1: data port owns the access, 0: fetch port
    logic        grant;
    logic        grant_mem;
    logic        rd_last;
    logic [7:0]  rd_byte;
    logic [31:0] rd_word;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^{if_addr[31:22], mem_addr[31:22]};

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_mem;

    assign grant_mem = mem_req && (!if_req || prio_mem);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio_mem <= 1'b1;
        else if (grant)
            prio_mem <= !grant_mem;
    end
`else
    assign grant_mem = mem_req;
`endif

    assign grant   = (state == IDLE) && (if_req || mem_req);
    assign rd_last = (state == RD) && (wait_cnt == 3'd0);

    always_comb begin
        rd_byte = ram_rdata[{addr_q[1:0], 3'b000} +: 8];
        rd_word = byte_q ? {{24{rd_byte[7]}}, rd_byte} : ram_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            id_q     <= 1'b0;
            wait_cnt <= '0;
        end else if (grant) begin
            id_q     <= grant_mem;
            addr_q   <= grant_mem ? mem_addr[21:0] : if_addr[21:0];
            we_q     <= grant_mem && mem_we;
            byte_q   <= grant_mem && mem_byte;
            wdata_q  <= (grant_mem && mem_byte) ? {4{mem_wdata[7:0]}} : mem_wdata;
            wait_cnt <= 3'(RD_WAIT);
        end else if (state == RD && wait_cnt != 3'd0) begin
            wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // Read data registers only change when a read for that port finishes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else if (rd_last) begin
            if (id_q)
                mem_rdata <= rd_word;
            else
                if_rdata  <= rd_word;
        end
    end

    always_comb begin
        state_nxt   = state;
        ram_ce_n    = 1'b1;
        ram_oe_n    = 1'b1;
        ram_we_n    = 1'b1;
        ram_be_n    = 4'b1111;
        ram_data_oe = 1'b0;
        if_ack      = 1'b0;
        mem_ack     = 1'b0;

        case (state)
            IDLE: begin
                if (grant)
                    state_nxt = (grant_mem && mem_we) ? WR_SETUP : RD;
            end
            RD: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
                ram_be_n = byte_q ? ~(4'b0001 << addr_q[1:0]) : 4'b0000;
                if (wait_cnt == 3'd0)
                    state_nxt = DONE;
            end
            WR_SETUP, WR_PULSE, WR_HOLD: begin
                ram_ce_n    = 1'b0;
                ram_data_oe = 1'b1;
                ram_be_n    = byte_q ? ~(4'b0001 << addr_q[1:0]) : 4'b0000;
                if (state == WR_SETUP)
                    state_nxt = WR_PULSE;
                else if (state == WR_PULSE) begin
                    ram_we_n  = 1'b0;
                    state_nxt = WR_HOLD;
                end else
                    state_nxt = DONE;
            end
            DONE: begin
                if_ack    = !id_q;
                mem_ack   = id_q;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign ram_sel   = addr_q[20];
    assign ram_addr  = addr_q[21:2];
    assign ram_wdata = wdata_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter: RD_WAIT, 1, extra SRAM read strobe cycles (0..7).
REQ-002 SHALL have port: clk  in  1  system clock, all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: if_req in 1, if_addr in 32, if_ack out 1, if_rdata out 32 (instruction fetch, read-only, word).
REQ-005 SHALL have ports: mem_req in 1, mem_we in 1, mem_byte in 1, mem_addr in 32, mem_wdata in 32, mem_ack out 1, mem_rdata out 32 (data port).
REQ-006 SHALL have ports: ram_sel out 1 (0 BaseRAM, 1 ExtRAM), ram_addr out 20, ram_be_n out 4, ram_ce_n out 1, ram_oe_n out 1, ram_we_n out 1, ram_wdata out 32, ram_data_oe out 1, ram_rdata in 32.

Function
REQ-007 SHALL implement states IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
REQ-008 SHALL sample if_req/mem_req only in IDLE; on grant latch addr, we, byte, wdata, requester id into registers.
REQ-009 SHALL grant mem over if when both asserted in the same IDLE cycle (default priority, see REQ-021).
REQ-010 SHALL derive ram_sel = addr[20], ram_addr = addr[21:2] of the latched address.
REQ-011 Read: IDLE->RD; RD lasts 1+RD_WAIT cycles with ce_n=0, oe_n=0, we_n=1, ram_data_oe=0; ram_rdata captured at the last RD edge; then DONE.
REQ-012 Write: WR_SETUP (ce_n=0, we_n=1, oe_n=1, ram_data_oe=1), WR_PULSE (we_n=0), WR_HOLD (we_n=1, data still driven), each exactly 1 cycle, then DONE.
REQ-013 DONE SHALL last 1 cycle, assert the granted port's ack for exactly that cycle, return to IDLE; next grant earliest in the following cycle.
REQ-014 Latency: req seen in IDLE at cycle 0 -> read ack at cycle 2+RD_WAIT, write ack at cycle 4.
REQ-015 Word access: ram_be_n=4'b0000, data unshifted.
REQ-016 Byte access (mem_byte=1): ram_be_n has only bit addr[1:0] low; write data byte replicated on all four lanes; read byte selected by addr[1:0] and sign-extended to 32 bits.
REQ-017 if_rdata/mem_rdata SHALL be registered and hold their value until the next read for that port completes.
REQ-018 Requester deasserting req mid-transaction SHALL NOT abort it; the access completes and ack still pulses.
REQ-019 In IDLE: ce_n=oe_n=we_n=1, ram_be_n=4'b1111, ram_data_oe=0; oe_n and we_n SHALL never be low together.

Reset
REQ-020 rst high SHALL immediately force state IDLE, ram_ce_n=ram_oe_n=ram_we_n=1, ram_be_n=4'b1111, ram_data_oe=0, ram_sel=0, ram_addr=0, ram_wdata=0, acks=0, if_rdata=mem_rdata=0, priority pointer to mem; an in-flight access is dropped without ack.

Configuration
REQ-021 Macro ARB_ROUND_ROBIN_EN: defined -> on simultaneous requests grant the port not granted last (pointer updates on each grant); undefined -> fixed mem priority, if port may starve while mem_req stays high.

Verification
REQ-022 if_req=1, if_addr=0x8000_0010, ram_rdata=0x2001_0001, RD_WAIT=1 -> ram_sel=0, ram_addr=0x00004, if_ack pulse at cycle 3, if_rdata=0x2001_0001.
REQ-023 mem_req=1, mem_we=1, mem_byte=1, mem_addr=0x8010_0003, mem_wdata=0xAB -> ram_sel=1, ram_be_n=4'b0111, ram_wdata=0xABABABAB, one we_n low cycle, mem_ack at cycle 4.
REQ-024 Byte read addr[1:0]=2, ram_rdata=0x0080_0000 -> mem_rdata=0xFFFF_FF80.
REQ-025 if_req and mem_req held high for 4 transactions -> without macro grants mem,mem,mem,mem; with ARB_ROUND_ROBIN_EN grants mem,if,mem,if.
REQ-026 rst pulsed during WR_PULSE -> we_n=1, ram_data_oe=0 same cycle, no mem_ack, state IDLE.
